// File: rtl/mcdf_channel_arbiter.sv
// mcdf_channel_arbiter: picks a ready channel FIFO by priority with round-robin
// tie-break, then drains one packet of words from it into the formatter stream.
module mcdf_channel_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_en,
    input  logic [2:0]               cfg_ch_en,
    input  logic [5:0]               cfg_prio,
    input  logic [1:0]               cfg_pkt_len,
    input  logic [3*LEVEL_WIDTH-1:0] ch_level,
    input  logic [3*DATA_WIDTH-1:0]  ch_data,
    output logic [2:0]               ch_rd_en,
    input  logic                     fmt_grant,
    output logic                     fmt_req,
    output logic [1:0]               fmt_chid,
    output logic [5:0]               fmt_len,
    output logic                     fmt_valid,
    output logic [DATA_WIDTH-1:0]    fmt_data,
    output logic                     fmt_start,
    output logic                     fmt_end,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t     state_q, state_d;
    logic [1:0] chid_q, chid_d, last_q, last_d, win, idx, best;
    logic [5:0] len_q, len_d, cnt_q, cnt_d, need;
    logic [2:0] cand, pos, rd_en_q, rd_en_d;
    logic       found;
    logic       req_q, req_d, valid_q, valid_d, start_q, start_d, end_q, end_d, busy_q, busy_d;

    assign need = 6'd4 << cfg_pkt_len;

    always_comb begin
        for (int i = 0; i < 3; i++)
            cand[i] = cfg_en & cfg_ch_en[i] & (ch_level[LEVEL_WIDTH*i +: LEVEL_WIDTH] >= LEVEL_WIDTH'(need));
    end

    // Scan starts just after the last granted channel; strict < keeps the first tie.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        best  = 2'd3;
        pos   = 3'd0;
        idx   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            pos = {1'b0, last_q} + 3'(k);
            idx = pos >= 3'd3 ? 2'(pos - 3'd3) : pos[1:0];
            if (cand[idx] && (!found || cfg_prio[2*idx +: 2] < best)) begin
                found = 1'b1;
                win   = idx;
                best  = cfg_prio[2*idx +: 2];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chid_d  = chid_q;
        len_d   = len_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = REQ;
                chid_d  = win;
                len_d   = need;
            end
            REQ: if (fmt_grant) begin
                state_d = SEND;
                last_d  = chid_q;
                cnt_d   = 6'd0;
            end
            SEND: if (cnt_q == len_q) begin
                state_d = IDLE;
                chid_d  = 2'd0;
                len_d   = 6'd0;
            end else begin
                cnt_d = cnt_q + 6'd1;
            end
            default: state_d = IDLE;
        endcase
        req_d   = state_d == REQ;
        rd_en_d = (state_d == SEND && cnt_d < len_d) ? 3'b001 << chid_d : 3'd0;
        valid_d = state_d == SEND && cnt_d != 6'd0;
        start_d = state_d == SEND && cnt_d == 6'd1;
        end_d   = state_d == SEND && cnt_d == len_d;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            chid_q  <= 2'd0;
            len_q   <= 6'd0;
            last_q  <= 2'd2;
            cnt_q   <= 6'd0;
            rd_en_q <= 3'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chid_q  <= chid_d;
            len_q   <= len_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            start_q <= start_d;
            end_q   <= end_d;
            busy_q  <= busy_d;
        end
    end

    // FIFO data arrives one cycle after the read, so the word itself is muxed straight through.
    assign fmt_data  = valid_q ? ch_data[DATA_WIDTH*chid_q +: DATA_WIDTH] : '0;
    assign ch_rd_en  = rd_en_q;
    assign fmt_req   = req_q;
    assign fmt_chid  = chid_q;
    assign fmt_len   = len_q;
    assign fmt_valid = valid_q;
    assign fmt_start = start_q;
    assign fmt_end   = end_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mcdf_channel_arbiter.sv
// tb_mcdf_channel_arbiter: directed stimulus with FIFO model and queue scoreboard.
module tb_mcdf_channel_arbiter;
    localparam int DW = 32;
    localparam int LW = 7;

    logic          clk = 1'b0, rst = 1'b1, cfg_en = 1'b0, fmt_grant = 1'b0;
    logic [2:0]    cfg_ch_en = 3'd0;
    logic [5:0]    cfg_prio = 6'd0;
    logic [1:0]    cfg_pkt_len = 2'd0;
    logic [3*LW-1:0] ch_level;
    logic [3*DW-1:0] ch_data = '0;
    logic [2:0]    ch_rd_en;
    logic          fmt_req, fmt_valid, fmt_start, fmt_end, busy;
    logic [1:0]    fmt_chid;
    logic [5:0]    fmt_len;
    logic [DW-1:0] fmt_data;

    typedef struct packed {
        logic [1:0]    ch;
        logic [5:0]    len;
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } word_t;

    word_t sb[$];
    int    n_cmp = 0, n_err = 0;
    int    wr[3] = '{0, 0, 0};
    int    rd[3] = '{0, 0, 0};
    int    exp_sent[3] = '{0, 0, 0};
    int    base[3] = '{32'hA0, 32'h1100, 32'h2200};

    mcdf_channel_arbiter #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_ch_en(cfg_ch_en), .cfg_prio(cfg_prio),
        .cfg_pkt_len(cfg_pkt_len), .ch_level(ch_level), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
        .fmt_grant(fmt_grant), .fmt_req(fmt_req), .fmt_chid(fmt_chid), .fmt_len(fmt_len),
        .fmt_valid(fmt_valid), .fmt_data(fmt_data), .fmt_start(fmt_start), .fmt_end(fmt_end),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // FIFO model: level = writes - reads capped at 64, registered read data
    always_comb begin
        for (int i = 0; i < 3; i++)
            ch_level[LW*i +: LW] = LW'((wr[i] - rd[i]) > 64 ? 64 : (wr[i] - rd[i]));
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (ch_rd_en[i]) begin
                ch_data[DW*i +: DW] <= DW'(base[i] + rd[i]);
                rd[i] <= rd[i] + 1;
            end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 64'({fmt_req, ch_rd_en, fmt_valid, fmt_start, fmt_end, busy, fmt_chid, fmt_len}), 64'd0);
        chk({nm, "_data"}, 64'(fmt_data), 64'd0);
    endtask

    task automatic set_level(input int ch, input int n);
        wr[ch] = exp_sent[ch] + n;
    endtask

    // Push expected words, then watch one packet; abort>0 asserts rst at that valid beat.
    task automatic run_pkt(input int ch, input int len, input int gdel, input int abort);
        int  n, rq, rdc, vc, cyc;
        bit  seen, done;
        n = abort > 0 ? abort - 1 : len;
        for (int k = 0; k < n; k++)
            sb.push_back('{ch: 2'(ch), len: 6'(len), d: DW'(base[ch] + exp_sent[ch] + k),
                           s: k == 0, e: k == len - 1});
        exp_sent[ch] += abort > 0 ? abort : len;
        fmt_grant = gdel <= 1;
        rq = 0; rdc = 0; vc = 0; cyc = 0; seen = 0; done = 0;
        while (!done && cyc < 300) begin
            tick(1);
            cyc++;
            if (fmt_req) begin
                rq++;
                if (rq == 1) begin
                    chk($sformatf("req_chid_ch%0d", ch), 64'(fmt_chid), 64'(ch));
                    chk($sformatf("req_len_ch%0d", ch), 64'(fmt_len), 64'(len));
                end
                if (rq == gdel) fmt_grant = 1'b1;
            end
            if (ch_rd_en == 3'(1 << ch)) rdc++;
            if (fmt_valid) vc++;
            if (busy) seen = 1;
            if (abort > 0 && vc == abort) begin
                rst = 1'b1;
                #1;
                chk_zero("async_rst");
                done = 1;
            end else if (seen && !busy) begin
                done = 1;
            end
        end
        chk("pkt_done_in_time", 64'(done), 64'd1);
        chk($sformatf("req_cycles_ch%0d", ch), 64'(rq), 64'(gdel < 1 ? 1 : gdel));
        if (abort == 0) chk($sformatf("rd_en_cycles_ch%0d", ch), 64'(rdc), 64'(len));
    endtask

    initial forever begin
        word_t e;
        @(negedge clk);
        n_cmp++;
        if (fmt_valid) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_word: got data %0h with no expected word", fmt_data);
            end else begin
                e = sb.pop_front();
                if ({fmt_chid, fmt_len, fmt_data, fmt_start, fmt_end} !== e) begin
                    n_err++;
                    $display("FAIL sb_word: got ch %0d len %0d data %0h s %0b e %0b expected ch %0d len %0d data %0h s %0b e %0b",
                             fmt_chid, fmt_len, fmt_data, fmt_start, fmt_end, e.ch, e.len, e.d, e.s, e.e);
                end
            end
        end else if ({fmt_data, fmt_start, fmt_end} !== '0) begin
            n_err++;
            $display("FAIL idle_out: got data %0h s %0b e %0b expected 0", fmt_data, fmt_start, fmt_end);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk_zero("reset");
        rst = 1'b0;
        cfg_en = 1'b1;
        cfg_ch_en = 3'b111;
        tick(5);
        chk("no_req_levels0", 64'({fmt_req, busy}), 64'd0);

        // single 4-word packet from ch0, grant held
        cfg_ch_en = 3'b001;
        set_level(0, 4);
        run_pkt(0, 4, 1, 0);
        tick(3);
        chk("idle_after_single", 64'({fmt_req, busy}), 64'd0);

        // priority: ch1 (prio 0) drains first, then ch2 (prio 1), then ch0
        cfg_en = 1'b0;
        cfg_prio = {2'd1, 2'd0, 2'd2};
        cfg_ch_en = 3'b111;
        set_level(0, 1000);
        set_level(1, 4);
        set_level(2, 8);
        cfg_en = 1'b1;
        run_pkt(1, 4, 1, 0);
        run_pkt(2, 4, 1, 0);
        run_pkt(2, 4, 1, 0);
        run_pkt(0, 4, 1, 0);
        cfg_en = 1'b0;
        tick(4);
        chk("cfg_en_off_no_req", 64'({fmt_req, busy}), 64'd0);

        // round-robin after a reset: 0,1,2,0,1,2
        rst = 1'b1;
        #1;
        chk_zero("reset_mid_sim");
        tick(1);
        rst = 1'b0;
        cfg_prio = 6'd0;
        cfg_pkt_len = 2'd1;
        for (int i = 0; i < 3; i++) set_level(i, 1000);
        cfg_en = 1'b1;
        for (int r = 0; r < 6; r++) run_pkt(r % 3, 8, 1, 0);
        cfg_en = 1'b0;
        tick(2);

        // threshold 32 on ch2 and a grant delayed to the 10th request cycle
        cfg_ch_en = 3'b100;
        cfg_pkt_len = 2'd3;
        set_level(2, 31);
        cfg_en = 1'b1;
        tick(6);
        chk("no_req_level31", 64'({fmt_req, busy}), 64'd0);
        set_level(2, 32);
        run_pkt(2, 32, 10, 0);
        cfg_en = 1'b0;
        tick(2);

        // reset at the 3rd beat of an 8-word ch1 packet, then rearbitrate from ch0
        cfg_ch_en = 3'b010;
        cfg_pkt_len = 2'd1;
        set_level(1, 1000);
        cfg_en = 1'b1;
        run_pkt(1, 8, 1, 3);
        cfg_ch_en = 3'b111;
        set_level(0, 1000);
        set_level(2, 1000);
        tick(2);
        chk_zero("held_in_reset");
        rst = 1'b0;
        run_pkt(0, 8, 1, 0);
        cfg_en = 1'b0;
        tick(5);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mcdf_channel_arbiter.md
# mcdf_channel_arbiter

Packet scheduler between the three 64-deep slave-channel FIFOs and the formatter in the MCDF datapath. Each cycle in idle, it selects one enabled channel whose FIFO level covers a full packet, using programmable priority with round-robin tie-break. It requests the formatter and, once granted, drains exactly one packet of words from that FIFO into the formatter stream, tagged with channel id, length and start/end markers.

## Interface
Parameters:
- DATA_WIDTH, 32, channel/formatter data width
- LEVEL_WIDTH, 7, width of each FIFO word-count input (0..64)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- cfg_en  input  1  global arbitration enable
- cfg_ch_en  input  3  per-channel enable, bit i = channel i
- cfg_prio  input  6  2-bit priority per channel, [2i+1:2i] = channel i; 0 highest
- cfg_pkt_len  input  2  packet length code: 0→4, 1→8, 2→16, 3→32 words
- ch_level  input  3*LEVEL_WIDTH  FIFO word counts, [LEVEL_WIDTH*i +: LEVEL_WIDTH] = channel i
- ch_data  input  3*DATA_WIDTH  FIFO data_out buses, registered, valid one cycle after read enable
- ch_rd_en  output  3  one-hot FIFO read enables
- fmt_grant  input  1  formatter accepts the pending request
- fmt_req  output  1  packet request to formatter
- fmt_chid  output  2  channel of current packet
- fmt_len  output  6  word count of current packet (4/8/16/32)
- fmt_valid  output  1  fmt_data carries a packet word
- fmt_data  output  DATA_WIDTH  packet word, 0 when fmt_valid low
- fmt_start  output  1  first word of packet
- fmt_end  output  1  last word of packet
- busy  output  1  state ≠ IDLE

## Operation
- Reset: state IDLE, all outputs 0, last_ch = 2 (so channel 0 wins first tie).
- States: IDLE, REQ, SEND.
- IDLE: candidate i = cfg_en & cfg_ch_en[i] & (ch_level_i ≥ decoded cfg_pkt_len). If any candidate: winner = lowest cfg_prio among candidates; ties broken round-robin, searching from last_ch+1 upward mod 3. Latch chid, len; go REQ. cfg_* read only here; later changes do not affect the packet in flight.
- REQ: fmt_req = 1, fmt_chid/fmt_len stable. On fmt_grant = 1, go SEND, last_ch ← chid. No timeout; waits indefinitely.
- SEND: 6-bit counter 0..len. ch_rd_en[chid] = 1 while count < len. fmt_valid = 1 while count ≥ 1; fmt_data = ch_data of chid. fmt_start with count = 1, fmt_end with count = len. After count = len, go IDLE.
- fmt_chid/fmt_len held from REQ entry through the fmt_end cycle; 0 in IDLE.
- No underflow: the arbiter is the FIFOs' only reader and level only grows from writes, so level ≥ len at selection guarantees len words.
- cfg_en or cfg_ch_en dropping during REQ/SEND: current packet completes; affects only next selection.
- fmt_grant outside REQ: ignored.

## Timing
- All outputs registered.
- IDLE selection evaluated at cycle t → fmt_req high from t+1.
- Grant sampled at cycle g → fmt_req low from g+1; ch_rd_en high g+1..g+len; fmt_valid high g+2..g+len+1; fmt_end at g+len+1.
- IDLE at g+len+2; next fmt_req no earlier than g+len+3. This gives at least one dead cycle between packets.
- Async rst at any point: outputs 0 immediately. Partial packet abandoned with no fmt_end. FIFO words already read are lost.

## Test plan
- Reset values: assert rst mid-sim → all outputs 0, busy 0; release with all levels 0 → fmt_req stays 0.
- Single packet: cfg_en=1, ch_en=3'b001, pkt_len=0, ch0 level 4, data 0xA0..0xA3, grant held high → fmt_req 1 cycle; rd_en[0] 4 cycles; fmt_valid 4 cycles with 0xA0..0xA3; start on 0xA0, end on 0xA3; chid 0, len 4.
- Priority: all channels level 64, prio ch0=2, ch1=0, ch2=1 → packet order 1,2… while levels suffice.
- Round-robin: equal prio, all levels 64, pkt_len=1 → chid sequence 0,1,2,0,1,2.
- Threshold and delayed grant: pkt_len=3 (32), ch2 level 31 → no req; level 32 → req; grant after 10 cycles → fmt_req high exactly 10 cycles, then 32 valid words.
- Reset mid-packet: rst at 3rd fmt_valid of an 8-word packet → outputs 0 at once, no fmt_end. After release, idle and rearbitration from channel 0.
